inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Streaming RV32I instruction encoder, the inverse of the control decoder: accepts field tuples and emits 32-bit instruction words with word addresses.
- Used by the self-test loader to fill instruction memory before the pipeline is released.
- Checks each tuple for legality and immediate range.
- Has a session FSM, one registered output stage with valid/ready, an address counter and an error counter.

Parameters:
- ADDR_W, 10, width of output word address; the address wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, word address loaded at session start.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  pulse; starts a session (honoured only in IDLE).
- in_valid  in  1  field tuple valid.
- in_ready  out  1  tuple accepted when in_valid && in_ready.
- in_class  in  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP; 9-15 are illegal.
- in_funct3  in  3  funct3 field.
- in_alt  in  1  selects funct7=0100000 (SUB/SRA/SRAI).
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_imm  in  32  signed immediate value (full value, not a pre-shifted field).
- in_last  in  1  marks the final tuple of the session.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address of out_inst.
- err_pulse  out  1  one-cycle pulse on an illegal accepted tuple.
- err_count  out  8  saturating illegal-tuple count for the session.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when the session completes.

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter = BASE_ADDR; output register empty.
- FSM states are IDLE, RUN, DRAIN.
  - IDLE to RUN on start: load addr = BASE_ADDR and clear err_count.
  - RUN to DRAIN on accepting a tuple with in_last=1.
  - DRAIN to IDLE when the output register is empty (immediately if the last tuple was illegal). done pulses in the cycle of the DRAIN to IDLE transition.
- in_ready = (state==RUN) && (!out_valid || out_ready); this gives full throughput with no bubble.
- Latency: a legal tuple accepted in cycle N appears on out_* in cycle N+1. out_* stay stable while out_valid && !out_ready.
- out_addr is the counter value at acceptance. The counter increments (wrapping) only for legal tuples.
- Illegal tuple: accepted and consumed, no output word, no address increment. err_pulse fires in cycle N+1 and err_count increments, saturating at 255.
- Encodings (standard RV32I opcodes):
  - LUI 0110111 / AUIPC 0010111: legal iff imm[11:0]==0; word = imm[31:12]|rd|opcode.
  - JAL 1101111: imm in [-2^20, 2^20-2] and even; word = imm[20|10:1|11|19:12]|rd|opcode.
  - JALR 1100111: funct3==000 and imm in [-2048, 2047].
  - BRANCH 1100011: funct3 in {000,001,100,101,110,111}; imm in [-4096, 4094] and even; word = imm[12|10:5]|rs2|rs1|f3|imm[4:1|11]|opcode.
  - LOAD 0000011: funct3 in {000,001,010,100,101}; I-range.
  - STORE 0100011: funct3 in {000,001,010}; I-range; imm split [11:5]/[4:0].
  - OP_IMM 0010011: funct3 001/101 are shifts; legal iff imm[31:5]==0, and alt is allowed only with 101; word = {alt?0100000:0000000, imm[4:0]}. Other funct3 values need I-range, and alt must be 0.
  - OP 0110011: funct7 = 0100000 if alt, where alt is legal only with funct3 000/101; otherwise funct7 = 0.
- Fields not used by a class are ignored (no error). Range checks are signed 32-bit.
- start while busy: ignored. in_valid outside RUN: not accepted.
- Reset mid-session: output register dropped, FSM returns to IDLE, no done pulse.

Decomposition:
- Shared package holds the class codes, the RV32I opcode constants, and the funct3/funct7 constants already used by the control decoder.
- One combinational sub-module, inst_field_pack: class + fields produce word + legal. The FSM, counters and output register live in inst_encoder.

Test Plan:
- start; tuples addi x1,x0,5 then add x2,x1,x1 with last; out_ready=1 -> 0x00500093 @0, then 0x00108133 @1, then done one cycle after the second word.
- sub x3,x1,x2 (alt=1), then srai x4,x1,3 -> 0x402081B3, then 0x4030D213.
- lui x5 imm=0x12345000 -> 0x123452B7; lui with imm=0x12345001 -> no word, err_pulse, err_count=1, address unchanged.
- beq x1,x2,-8 -> 0xFE208CE3; jal x1,2048 -> 0x001000EF; jal with odd imm=3 -> error.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_inst and out_addr stable, no tuple lost.
- ADDR_W=2, BASE_ADDR=3, two legal words -> addresses 3 then 0. Reset mid-session -> busy=0, out_valid=0, no done.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoding constants: tuple classes, opcodes, funct3/funct7 codes
// and the encoder session states.
package inst_encoder_pkg;

    typedef enum logic [3:0] {
        CLS_LUI    = 4'd0,
        CLS_AUIPC  = 4'd1,
        CLS_JAL    = 4'd2,
        CLS_JALR   = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LOAD   = 4'd5,
        CLS_STORE  = 4'd6,
        CLS_OP_IMM = 4'd7,
        CLS_OP     = 4'd8
    } inst_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } enc_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;
    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_LBU     = 3'b100;
    localparam logic [2:0] F3_LHU     = 3'b101;
    localparam logic [2:0] F3_SB      = 3'b000;
    localparam logic [2:0] F3_SH      = 3'b001;
    localparam logic [2:0] F3_SW      = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // True when v is representable as an nbits-wide two's-complement value.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
        logic [31:0] hi;
        hi = $signed(v) >>> (nbits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational RV32I packer: class + fields -> 32-bit word and a legality flag.
// Zero latency, no flow control; word is don't-care when legal is low.
module inst_field_pack
    import inst_encoder_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic i_ok;
    logic even;
    logic is_shift;

    assign i_ok     = fits_signed(imm, 12);
    assign even     = ~imm[0];
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (cls)
            CLS_LUI: begin
                legal = (imm[11:0] == 12'd0);
                word  = {imm[31:12], rd, OPC_LUI};
            end
            CLS_AUIPC: begin
                legal = (imm[11:0] == 12'd0);
                word  = {imm[31:12], rd, OPC_AUIPC};
            end
            CLS_JAL: begin
                legal = fits_signed(imm, 21) && even;
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            end
            CLS_JALR: begin
                legal = (funct3 == F3_JALR) && i_ok;
                word  = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
            end
            CLS_BRANCH: begin
                legal = fits_signed(imm, 13) && even &&
                        (funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            end
            CLS_LOAD: begin
                legal = i_ok && (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
                word  = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            end
            CLS_STORE: begin
                legal = i_ok && (funct3 inside {F3_SB, F3_SH, F3_SW});
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            end
            CLS_OP_IMM: begin
                // Shift amounts live in the rs2 slot with funct7 above them.
                if (is_shift) begin
                    legal = (imm[31:5] == 27'd0) && (!alt || funct3 == F3_SRL_SRA);
                    word  = {alt ? F7_ALT : F7_BASE, imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
                end else begin
                    legal = i_ok && !alt;
                    word  = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
                end
            end
            CLS_OP: begin
                legal = !alt || (funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA);
                word  = {alt ? F7_ALT : F7_BASE, rs2, rs1, funct3, rd, OPC_OP};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder session: tuples in, addressed instruction words out.
// One cycle accept-to-output; in_ready drops only when the output register is held by !out_ready.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_pulse,
    output logic [7:0]        err_count,
    output logic              busy,
    output logic              done
);

    enc_state_e        state;
    enc_state_e        state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       pack_word;
    logic              pack_legal;
    logic              accept;

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);

    inst_field_pack u_pack (
        .cls    (in_class),
        .funct3 (in_funct3),
        .alt    (in_alt),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .word   (pack_word),
        .legal  (pack_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (accept && in_last) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                // An illegal final tuple leaves the register empty, so this can fire at once.
                if (!out_valid) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= ADDR_W'(BASE_ADDR);
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_addr  <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (state == ST_IDLE && start) begin
                addr      <= ADDR_W'(BASE_ADDR);
                err_count <= '0;
            end
            if (accept) begin
                if (pack_legal) begin
                    out_valid <= 1'b1;
                    out_inst  <= pack_word;
                    out_addr  <= addr;
                    addr      <= addr + ADDR_W'(1);
                end else begin
                    err_pulse <= 1'b1;
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: constant vector table, hand-written corner sequences and a
// random session scored against an arithmetic reference model (two address configs).
module tb_inst_encoder;

    typedef struct {
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } tup_t;

    typedef struct {
        tup_t        t;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        int          a;
        int          a2;
    } exp_t;

    logic clk;
    logic rst_n, start, in_valid, in_alt, in_last, out_ready;
    logic [3:0]  in_class;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_ready, out_valid, err_pulse, busy, done;
    logic [31:0] out_inst;
    logic [9:0]  out_addr;
    logic [7:0]  err_count;
    logic        in_ready2, out_valid2, err_pulse2, busy2, done2;
    logic [31:0] out_inst2;
    logic [1:0]  out_addr2;
    logic [7:0]  err_count2;

    int   checks = 0;
    int   fails  = 0;
    exp_t q[$];
    bit   m_busy, m_drain, exp_errp, stall_prev, acc, rnd_ready;
    int   m_errs, m_addr, m_addr2;
    logic [31:0] sv_inst;
    logic [9:0]  sv_addr;
    vec_t vt[26];
    logic [31:0] bnd[8] = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF,
                            32'h000FFFFE, 32'hFFF00000, 32'h00000FFE, 32'hFFFFF000};

    inst_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .err_pulse(err_pulse), .err_count(err_count), .busy(busy), .done(done)
    );

    inst_encoder #(.ADDR_W(2), .BASE_ADDR(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
        .in_class(in_class), .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2), .out_addr(out_addr2),
        .err_pulse(err_pulse2), .err_count(err_count2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    // Reference encoder: signed-integer range rules and arithmetic field placement.
    function automatic void ref_enc(input tup_t t, output logic legal, output logic [31:0] w);
        longint s;
        bit i_ok, even;
        logic [31:0] rd7, rs1_15, rs2_20, f3_12, f7;
        s      = longint'($signed(t.imm));
        i_ok   = (s >= -2048) && (s <= 2047);
        even   = (t.imm % 2) == 0;
        rd7    = 32'(t.rd) << 7;
        rs1_15 = 32'(t.rs1) << 15;
        rs2_20 = 32'(t.rs2) << 20;
        f3_12  = 32'(t.f3) << 12;
        f7     = t.alt ? 32'h40000000 : 32'h0;
        legal  = 1'b0;
        w      = 32'h0;
        case (t.cls)
            4'd0, 4'd1: begin
                legal = (t.imm % 4096) == 0;
                w = (t.imm - t.imm % 4096) + rd7 + ((t.cls == 4'd0) ? 32'h37 : 32'h17);
            end
            4'd2: begin
                legal = (s >= -1048576) && (s <= 1048574) && even;
                w = (fld(t.imm, 20, 20) << 31) + (fld(t.imm, 10, 1) << 21) +
                    (fld(t.imm, 11, 11) << 20) + (fld(t.imm, 19, 12) << 12) + rd7 + 32'h6F;
            end
            4'd3: begin
                legal = (t.f3 == 3'd0) && i_ok;
                w = (fld(t.imm, 11, 0) << 20) + rs1_15 + rd7 + 32'h67;
            end
            4'd4: begin
                legal = (t.f3 != 3'd2) && (t.f3 != 3'd3) && (s >= -4096) && (s <= 4094) && even;
                w = (fld(t.imm, 12, 12) << 31) + (fld(t.imm, 10, 5) << 25) + rs2_20 + rs1_15 +
                    f3_12 + (fld(t.imm, 4, 1) << 8) + (fld(t.imm, 11, 11) << 7) + 32'h63;
            end
            4'd5: begin
                legal = (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && i_ok;
                w = (fld(t.imm, 11, 0) << 20) + rs1_15 + f3_12 + rd7 + 32'h03;
            end
            4'd6: begin
                legal = (t.f3 <= 3'd2) && i_ok;
                w = (fld(t.imm, 11, 5) << 25) + rs2_20 + rs1_15 + f3_12 + (fld(t.imm, 4, 0) << 7) + 32'h23;
            end
            4'd7: begin
                if (t.f3 == 3'd1 || t.f3 == 3'd5) begin
                    legal = (t.imm < 32) && (!t.alt || t.f3 == 3'd5);
                    w = f7 + (fld(t.imm, 4, 0) << 20) + rs1_15 + f3_12 + rd7 + 32'h13;
                end else begin
                    legal = i_ok && !t.alt;
                    w = (fld(t.imm, 11, 0) << 20) + rs1_15 + f3_12 + rd7 + 32'h13;
                end
            end
            4'd8: begin
                legal = !t.alt || t.f3 == 3'd0 || t.f3 == 3'd5;
                w = f7 + rs2_20 + rs1_15 + f3_12 + rd7 + 32'h33;
            end
            default: ;
        endcase
    endfunction

    // Per-cycle scoreboard, sampled at the falling edge.
    task automatic monitor();
        bit   exp_done, legal_m;
        logic [31:0] w;
        exp_t e;
        tup_t t;
        if (!rst_n) begin
            q.delete();
            m_busy = 0; m_drain = 0; m_errs = 0; exp_errp = 0; stall_prev = 0; acc = 0;
            return;
        end
        exp_done = m_drain && (q.size() == 0);
        chk("busy", busy, m_busy);
        chk("busy2", busy2, m_busy);
        chk("done", done, exp_done);
        chk("done2", done2, exp_done);
        chk("out_valid", out_valid, q.size() != 0);
        chk("out_valid2", out_valid2, q.size() != 0);
        chk("in_ready", in_ready, m_busy && !m_drain && (q.size() == 0 || out_ready));
        chk("in_ready2", in_ready2, m_busy && !m_drain && (q.size() == 0 || out_ready));
        chk("err_pulse", err_pulse, exp_errp);
        chk("err_pulse2", err_pulse2, exp_errp);
        chk("err_count", err_count, m_errs);
        chk("err_count2", err_count2, m_errs);
        if (stall_prev) begin
            chk("stall_inst", out_inst, sv_inst);
            chk("stall_addr", out_addr, sv_addr);
        end
        stall_prev = out_valid && !out_ready;
        sv_inst = out_inst;
        sv_addr = out_addr;
        if (out_valid && out_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("sb_inst", out_inst, e.inst);
            chk("sb_addr", out_addr, e.a);
            chk("sb_inst2", out_inst2, e.inst);
            chk("sb_addr2", out_addr2, e.a2);
        end
        if (exp_done) begin
            m_busy = 0;
            m_drain = 0;
        end
        exp_errp = 0;
        if (start && !m_busy) begin
            m_busy = 1; m_addr = 0; m_addr2 = 3; m_errs = 0;
        end
        acc = 0;
        if (in_valid && in_ready) begin
            acc = 1;
            t = '{in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm};
            ref_enc(t, legal_m, w);
            if (legal_m) begin
                q.push_back('{w, m_addr, m_addr2});
                m_addr  = (m_addr + 1) % 1024;
                m_addr2 = (m_addr2 + 1) % 4;
            end else begin
                exp_errp = 1;
                if (m_errs < 255) m_errs++;
            end
            if (in_last) m_drain = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input tup_t t, input logic last);
        in_class = t.cls; in_funct3 = t.f3; in_alt = t.alt; in_rd = t.rd;
        in_rs1 = t.rs1; in_rs2 = t.rs2; in_imm = t.imm; in_last = last;
        in_valid = 1'b1;
    endtask

    task automatic send(input tup_t t, input logic last);
        drive(t, last);
        acc = 0;
        for (int k = 0; k < 64 && !acc; k++) tick();
        if (!acc) begin
            fails++;
            $display("FAIL send_timeout tuple not accepted within 64 cycles at %0t", $time);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && busy; k++) tick();
        checks++;
        if (busy) begin
            fails++;
            $display("FAIL idle_timeout busy still 1 after 400 cycles at %0t", $time);
        end
        tick();
    endtask

    function automatic tup_t tp(input int cls, input int f3, input int alt, input int rd,
                                input int rs1, input int rs2, input logic [31:0] imm);
        tup_t t;
        t.cls = 4'(cls); t.f3 = 3'(f3); t.alt = 1'(alt);
        t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.imm = imm;
        return t;
    endfunction

    function automatic vec_t mk(input tup_t t, input bit legal, input logic [31:0] w);
        vec_t v;
        v.t = t; v.legal = legal; v.word = w;
        return v;
    endfunction

    function automatic tup_t rnd_tup();
        tup_t t;
        t.cls = 4'($urandom_range(0, 9));
        t.f3  = 3'($urandom_range(0, 7));
        t.alt = ($urandom_range(0, 3) == 0);
        t.rd  = 5'($urandom_range(0, 31));
        t.rs1 = 5'($urandom_range(0, 31));
        t.rs2 = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 5))
            0:       t.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1:       t.imm = $urandom;
            2:       t.imm = $urandom & 32'hFFFFF000;
            3:       t.imm = 32'($urandom_range(0, 40));
            4:       t.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            default: t.imm = bnd[$urandom_range(0, 7)];
        endcase
        return t;
    endfunction

    initial begin
        int ea;
        rst_n = 0; start = 0; in_valid = 0; in_last = 0; out_ready = 1; rnd_ready = 0;
        in_class = 0; in_funct3 = 0; in_alt = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;

        vt[0]  = mk(tp(7, 0, 0, 1, 0, 0, 32'd5),         1, 32'h00500093);
        vt[1]  = mk(tp(8, 0, 0, 2, 1, 1, 32'd0),         1, 32'h00108133);
        vt[2]  = mk(tp(8, 0, 1, 3, 1, 2, 32'd0),         1, 32'h402081B3);
        vt[3]  = mk(tp(7, 5, 1, 4, 1, 0, 32'd3),         1, 32'h4030D213);
        vt[4]  = mk(tp(0, 0, 0, 5, 0, 0, 32'h12345000),  1, 32'h123452B7);
        vt[5]  = mk(tp(0, 0, 0, 5, 0, 0, 32'h12345001),  0, 32'h0);
        vt[6]  = mk(tp(4, 0, 0, 0, 1, 2, 32'hFFFFFFF8),  1, 32'hFE208CE3);
        vt[7]  = mk(tp(2, 0, 0, 1, 0, 0, 32'h800),       1, 32'h001000EF);
        vt[8]  = mk(tp(2, 0, 0, 1, 0, 0, 32'd3),         0, 32'h0);
        vt[9]  = mk(tp(9, 0, 0, 1, 1, 1, 32'd0),         0, 32'h0);
        vt[10] = mk(tp(7, 0, 0, 1, 0, 0, 32'h800),       0, 32'h0);
        vt[11] = mk(tp(7, 0, 0, 1, 0, 0, 32'hFFFFF800),  1, 32'h80000093);
        vt[12] = mk(tp(7, 1, 1, 1, 1, 0, 32'd1),         0, 32'h0);
        vt[13] = mk(tp(7, 1, 0, 1, 1, 0, 32'd32),        0, 32'h0);
        vt[14] = mk(tp(4, 2, 0, 0, 1, 2, 32'd8),         0, 32'h0);
        vt[15] = mk(tp(3, 0, 0, 1, 2, 0, 32'hFFFFFFFF),  1, 32'hFFF100E7);
        vt[16] = mk(tp(6, 2, 0, 0, 1, 2, 32'hFFFFFFFC),  1, 32'hFE20AE23);
        vt[17] = mk(tp(1, 0, 0, 10, 0, 0, 32'hFFFFF000), 1, 32'hFFFFF517);
        vt[18] = mk(tp(2, 0, 0, 0, 0, 0, 32'h000FFFFE),  1, 32'h7FFFF06F);
        vt[19] = mk(tp(2, 0, 0, 0, 0, 0, 32'h00100000),  0, 32'h0);
        vt[20] = mk(tp(8, 6, 1, 1, 1, 1, 32'd0),         0, 32'h0);
        vt[21] = mk(tp(5, 3, 0, 1, 1, 0, 32'd0),         0, 32'h0);
        vt[22] = mk(tp(5, 2, 0, 5, 6, 0, 32'h7FF),       1, 32'h7FF32283);
        vt[23] = mk(tp(4, 1, 0, 0, 3, 4, 32'hFFE),       1, 32'h7E419FE3);
        vt[24] = mk(tp(7, 1, 0, 1, 1, 0, 32'd31),        1, 32'h01F09093);
        vt[25] = mk(tp(8, 5, 1, 7, 8, 9, 32'd0),         1, 32'h409453B3);

        tick(); tick();
        rst_n = 1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_addr2", out_addr2, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick();

        // Two-word session: addi then add with last; done one cycle after the final word.
        pulse_start();
        send(vt[0].t, 0);
        chk("s1_w0_inst", out_inst, 32'h00500093);
        chk("s1_w0_addr", out_addr, 0);
        chk("s1_w0_addr2", out_addr2, 3);
        send(vt[1].t, 1);
        chk("s1_w1_inst", out_inst, 32'h00108133);
        chk("s1_w1_addr", out_addr, 1);
        chk("s1_w1_addr2", out_addr2, 0);
        chk("s1_w1_done", done, 0);
        tick();
        chk("s1_done", done, 1);
        tick();
        chk("s1_idle", busy, 0);

        // Vector table, one tuple at a time with the consumer always ready.
        pulse_start();
        ea = 0;
        for (int i = 0; i < 26; i++) begin
            send(vt[i].t, i == 25);
            chk($sformatf("tbl%0d_valid", i), out_valid, vt[i].legal);
            chk($sformatf("tbl%0d_err", i), err_pulse, !vt[i].legal);
            if (vt[i].legal) begin
                chk($sformatf("tbl%0d_inst", i), out_inst, vt[i].word);
                chk($sformatf("tbl%0d_addr", i), out_addr, ea);
                ea++;
            end
        end
        wait_idle();

        // Error counter saturation.
        pulse_start();
        for (int i = 0; i < 260; i++) send(tp(15, 0, 0, 0, 0, 0, 32'd0), i == 259);
        wait_idle();
        chk("sat_err_count", err_count, 8'd255);

        // Backpressure: three stalled cycles with a pending tuple; a start here is ignored.
        pulse_start();
        chk("stall_err_cleared", err_count, 0);
        out_ready = 0;
        send(tp(7, 0, 0, 1, 0, 0, 32'd1), 0);
        drive(tp(8, 0, 1, 3, 1, 2, 32'd0), 1);
        start = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 0;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_hold_inst", out_inst, 32'h00100093);
            chk("stall_hold_addr", out_addr, 0);
        end
        out_ready = 1;
        send(tp(8, 0, 1, 3, 1, 2, 32'd0), 1);
        chk("stall_next_inst", out_inst, 32'h402081B3);
        chk("stall_next_addr", out_addr, 1);
        wait_idle();

        // Randomised session with a random consumer.
        rnd_ready = 1;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (i == 150) start = 1;
            send(rnd_tup(), i == 299);
            start = 0;
        end
        rnd_ready = 0;
        out_ready = 1;
        wait_idle();

        // Reset in the middle of a session with a word held in the output register.
        pulse_start();
        out_ready = 0;
        send(tp(7, 0, 0, 1, 0, 0, 32'd5), 0);
        chk("mid_held", out_valid, 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("mid_busy", busy, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_done", done, 0);
        tick();
        chk("mid_done_after", done, 0);
        out_ready = 1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
